cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Sequencing controller for the 4-set × 4-way, 8-bit-tag cache tag store. It accepts one lookup request at a time, qualifies raw tag-compare hits with its own valid bits, and selects a victim on a miss. It runs the dirty writeback and line fill over a req/ack memory handshake, then writes the new tag into the tag store. It sits between the M-stage access logic and the tag store/data array, and owns all valid, dirty and replacement state.

## Interface
Parameters:
- TAG_W, 8, tag width; must match the tag store
- SETS, 4, number of sets (index width 2)
- WAYS, 4, associativity; one-hot way select width

Ports:
- clk  in  1  clock, all state rising-edge
- clr  in  1  reset, asynchronous, active-low
- req_v  in  1  request valid
- req_rw  in  1  1 = write (marks line dirty), 0 = read
- req_addr  in  10  {tag[7:0], index[1:0]}
- req_ready  out  1  high only in IDLE; request accepted on edge with req_v & req_ready
- resp_v  out  1  one-cycle response pulse
- resp_hit  out  1  1 = hit, 0 = serviced miss
- resp_way  out  4  one-hot way now holding the line
- ts_index  out  2  tag store index
- ts_tag  out  8  tag store compare/write tag
- ts_way  out  4  one-hot tag store write way
- ts_w  out  1  tag store write strobe
- ts_hit  in  4  raw per-way tag compare from tag store
- ts_dump  in  32  all four stored tags of ts_index, way i at [8i+7:8i]
- mem_req  out  1  memory request
- mem_we  out  1  1 = writeback, 0 = fill read
- mem_addr  out  10  {tag, index} of line
- mem_ack  in  1  memory done; sampled only while mem_req high

## Operation
- State: valid[16], dirty[16] (index × way), rr[4] 2-bit round-robin counter per set, latched request (tag, index, rw), latched victim way.
- FSM: IDLE → LOOKUP → (RESP | EVICT | FILL); EVICT → FILL → UPDATE → RESP → IDLE.
- IDLE: req_ready=1; on accept, latch request, go LOOKUP.
- LOOKUP: ts_index/ts_tag driven from latch; qhit = ts_hit & valid[index].
  - qhit≠0: hit way = lowest set bit of qhit; if rw, set dirty; go RESP with resp_hit=1.
  - qhit=0: victim = lowest-numbered invalid way, else way rr[index]. Victim valid & dirty → EVICT; otherwise → FILL.
- EVICT: mem_req=1, mem_we=1, mem_addr={ts_dump tag of victim, index}, victim tag latched at LOOKUP exit; hold until mem_ack, then FILL.
- FILL: mem_req=1, mem_we=0, mem_addr={req tag, index}; hold until mem_ack, then UPDATE.
- UPDATE: ts_w=1, ts_way=victim, ts_tag=req tag for exactly one cycle. Set valid, dirty=rw; rr[index] increments mod 4 on every fill of that set. Go RESP with resp_hit=0.
- RESP: resp_v=1 one cycle with resp_hit and resp_way; go IDLE.
- ts_w is never asserted outside UPDATE; mem_req is never asserted outside EVICT/FILL.

## Timing
- Reset (clr low, async): state IDLE, valid/dirty/rr all 0. req_ready=1; resp_v, resp_hit, resp_way, ts_w, ts_way, mem_req, mem_we = 0; mem_addr, ts_index, ts_tag = 0.
- Reset mid-operation: mem_req and ts_w drop immediately and any outstanding memory transaction is abandoned; memory must tolerate this.
- Hit: accept at edge 0, LOOKUP in cycle 1, resp_v in cycle 2; next accept at edge 3.
- Clean miss: resp_v 3 + F cycles after accept, where F = FILL cycles including the ack cycle (F ≥ 1). Dirty miss adds E EVICT cycles.
- mem_ack is a single-cycle strobe; mem_ack while mem_req=0 is ignored. mem_req falls on the edge that samples mem_ack.
- req_v outside IDLE is ignored; no queuing.

## Structure
- Shared package cache_pkg: FSM state encoding, TAG_W/SETS/WAYS constants, address field positions (tag [9:2], index [1:0]).
- One sub-module, cache_victim_sel: combinational; inputs valid[3:0] of set and rr[1:0]; outputs one-hot victim way and a victim_valid flag.
- Valid/dirty/rr storage and the FSM live in cache_ctrl.

## Test plan
- After reset, read 0x2A1 (tag 0xA8, idx 1) → miss, FILL mem_addr=0x2A1. Ack after 2 cycles → ts_w with ts_way=0001, ts_tag=0xA8; then resp_v, resp_hit=0, resp_way=0001.
- Repeat read 0x2A1 with ts_hit=0001 → resp_v exactly 2 cycles after accept, resp_hit=1, resp_way=0001, no mem_req.
- Fill idx 1 with 4 distinct tags, then a fifth → victims 0,1,2,3 in order, then way 0 (rr=0). No EVICT while all lines are clean.
- Write-hit way 2 of idx 3 (tag 0x11), then miss in a full idx 3 with rr=2 → EVICT mem_we=1, mem_addr=0x047, then FILL with the new address, dirty[3][2] equal to new req_rw.
- ts_hit=0100 but valid=0 for that way → treated as miss; victim = lowest invalid way.
- Pull clr low during FILL with mem_req=1 → mem_req=0 immediately, req_ready=1. The next lookup of the previously filled address misses, since all valid bits are cleared.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the cache sequencing controller.
//   - default geometry (tag width, sets, ways) for the 4x4 tag store
//   - request address field positions: {tag, index}
//   - controller FSM state encoding
package cache_pkg;

  localparam int DEF_TAG_W = 8;
  localparam int DEF_SETS  = 4;
  localparam int DEF_WAYS  = 4;
  localparam int DEF_IDX_W = $clog2(DEF_SETS);

  // Request address layout: index in the low bits, tag above it.
  localparam int ADDR_IDX_LSB = 0;
  localparam int ADDR_TAG_LSB = DEF_IDX_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_EVICT,
    ST_FILL,
    ST_UPDATE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/cache_victim_sel.sv
// cache_victim_sel: combinational victim choice for one set.
//   i_valid        : valid bits of the set being looked up
//   i_rr           : round-robin pointer of that set
//   o_way          : one-hot victim way
//   o_victim_valid : 1 when the victim currently holds a valid line
// The lowest-numbered invalid way wins; with the set full, the
// round-robin pointer picks the way.
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter  int WAYS = DEF_WAYS,
  localparam int RR_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0] i_valid,
  input  logic [RR_W-1:0] i_rr,
  output logic [WAYS-1:0] o_way,
  output logic            o_victim_valid
);

  logic [WAYS-1:0] w_inv;
  logic [WAYS-1:0] w_inv_first;

  assign w_inv = ~i_valid;
  // x & -x isolates the lowest set bit
  assign w_inv_first = w_inv & (~w_inv + WAYS'(1));

  always_comb begin
    o_way          = '0;
    o_victim_valid = 1'b0;
    if (w_inv_first != '0) begin
      o_way = w_inv_first;
    end else begin
      o_way[i_rr]    = 1'b1;
      o_victim_valid = 1'b1;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: lookup / writeback / fill sequencer for the set-associative
// tag store. Owns valid, dirty and round-robin replacement state.
//   clk, clr              : clock, async active-low reset
//   req_v/req_rw/req_addr : one lookup at a time, accepted when req_ready
//   resp_v/hit/way        : one-cycle response, way one-hot
//   ts_*                  : tag store index/tag, write strobe + way,
//                           raw compare hits and full tag dump of the set
//   mem_*                 : req/ack memory port, we=1 writeback, we=0 fill
module cache_ctrl
  import cache_pkg::*;
#(
  parameter  int TAG_W  = DEF_TAG_W,
  parameter  int SETS   = DEF_SETS,
  parameter  int WAYS   = DEF_WAYS,
  localparam int IDX_W  = $clog2(SETS),
  localparam int RR_W   = $clog2(WAYS),
  localparam int ADDR_W = TAG_W + IDX_W
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  req_v,
  input  logic                  req_rw,
  input  logic [ADDR_W-1:0]     req_addr,
  output logic                  req_ready,
  output logic                  resp_v,
  output logic                  resp_hit,
  output logic [WAYS-1:0]       resp_way,
  output logic [IDX_W-1:0]      ts_index,
  output logic [TAG_W-1:0]      ts_tag,
  output logic [WAYS-1:0]       ts_way,
  output logic                  ts_w,
  input  logic [WAYS-1:0]       ts_hit,
  input  logic [WAYS*TAG_W-1:0] ts_dump,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_ack
);

  state_e r_state, w_nxt;

  logic [SETS-1:0][WAYS-1:0] r_valid;
  logic [SETS-1:0][WAYS-1:0] r_dirty;
  logic [SETS-1:0][RR_W-1:0] r_rr;

  logic [TAG_W-1:0] r_tag;   // latched request tag
  logic [IDX_W-1:0] r_idx;   // latched request index
  logic             r_rw;
  logic             r_hit;
  logic [WAYS-1:0]  r_way;   // hit way, or victim way on a miss
  logic [TAG_W-1:0] r_vtag;  // tag of the line being written back

  logic [WAYS-1:0]  w_qhit;
  logic [WAYS-1:0]  w_hit_way;
  logic [WAYS-1:0]  w_vway;
  logic             w_vvalid;
  logic [TAG_W-1:0] w_vtag;

  // Raw compares only count for lines we hold as valid.
  assign w_qhit    = ts_hit & r_valid[r_idx];
  assign w_hit_way = w_qhit & (~w_qhit + WAYS'(1));

  cache_victim_sel #(.WAYS(WAYS)) u_vsel (
    .i_valid        (r_valid[r_idx]),
    .i_rr           (r_rr[r_idx]),
    .o_way          (w_vway),
    .o_victim_valid (w_vvalid)
  );

  // Stored tag of the victim way, needed for the writeback address.
  always_comb begin
    w_vtag = '0;
    for (int i = 0; i < WAYS; i++)
      if (w_vway[i]) w_vtag = ts_dump[i*TAG_W +: TAG_W];
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= ST_IDLE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    req_ready = 1'b0;
    resp_v    = 1'b0;
    resp_hit  = 1'b0;
    resp_way  = '0;
    ts_way    = '0;
    ts_w      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_v) w_nxt = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (w_qhit != '0)                           w_nxt = ST_RESP;
        else if (w_vvalid && |(w_vway & r_dirty[r_idx])) w_nxt = ST_EVICT;
        else                                        w_nxt = ST_FILL;
      end
      ST_EVICT: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {r_vtag, r_idx};
        if (mem_ack) w_nxt = ST_FILL;
      end
      ST_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {r_tag, r_idx};
        if (mem_ack) w_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        ts_w   = 1'b1;
        ts_way = r_way;
        w_nxt  = ST_RESP;
      end
      ST_RESP: begin
        resp_v   = 1'b1;
        resp_hit = r_hit;
        resp_way = r_way;
        w_nxt    = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  // Tag store is addressed from the latch for the whole transaction.
  assign ts_index = r_idx;
  assign ts_tag   = r_tag;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_valid <= '0;
      r_dirty <= '0;
      r_rr    <= '0;
      r_tag   <= '0;
      r_idx   <= '0;
      r_rw    <= 1'b0;
      r_hit   <= 1'b0;
      r_way   <= '0;
      r_vtag  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (req_v) begin
            r_tag <= req_addr[IDX_W +: TAG_W];
            r_idx <= req_addr[0 +: IDX_W];
            r_rw  <= req_rw;
          end
        end
        ST_LOOKUP: begin
          r_hit <= (w_qhit != '0);
          if (w_qhit != '0) begin
            r_way <= w_hit_way;
            if (r_rw) r_dirty[r_idx] <= r_dirty[r_idx] | w_hit_way;
          end else begin
            r_way  <= w_vway;
            r_vtag <= w_vtag;
          end
        end
        ST_UPDATE: begin
          r_valid[r_idx] <= r_valid[r_idx] | r_way;
          r_dirty[r_idx] <= r_rw ? (r_dirty[r_idx] | r_way)
                                 : (r_dirty[r_idx] & ~r_way);
          // Advances on every fill of the set, including fills into
          // invalid ways.
          r_rr[r_idx]    <= r_rr[r_idx] + RR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed bench with scoreboard queues. Stimulus pushes
// expected responses, memory transactions and tag writes; independent
// monitors pop and compare when the DUT presents them. The bench models
// the tag store (tag array, raw compares, tag dump) and a memory that
// acks after ack_dly cycles.
module tb_cache_ctrl;

  logic        clk, clr;
  logic        req_v, req_rw;
  logic [9:0]  req_addr;
  logic        req_ready, resp_v, resp_hit;
  logic [3:0]  resp_way;
  logic [1:0]  ts_index;
  logic [7:0]  ts_tag;
  logic [3:0]  ts_way;
  logic        ts_w;
  logic [3:0]  ts_hit;
  logic [31:0] ts_dump;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic        mem_ack;

  cache_ctrl dut (
    .clk(clk), .clr(clr),
    .req_v(req_v), .req_rw(req_rw), .req_addr(req_addr), .req_ready(req_ready),
    .resp_v(resp_v), .resp_hit(resp_hit), .resp_way(resp_way),
    .ts_index(ts_index), .ts_tag(ts_tag), .ts_way(ts_way), .ts_w(ts_w),
    .ts_hit(ts_hit), .ts_dump(ts_dump),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int ack_dly = 2;
  int resp_cnt = 0;
  int resp_cyc = 0;

  logic [10:0] exp_mem[$];   // {we, addr}
  logic [13:0] exp_ts[$];    // {idx, way, tag}
  logic [4:0]  exp_resp[$];  // {hit, way}

  logic [7:0] tstore [4][4];
  logic       hit_ovr_en;
  logic [3:0] hit_ovr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Tag store model.
  always_comb begin
    ts_hit = '0;
    for (int i = 0; i < 4; i++) ts_hit[i] = (tstore[ts_index][i] == ts_tag);
    if (hit_ovr_en) ts_hit = hit_ovr;
  end
  always_comb begin
    ts_dump = '0;
    for (int i = 0; i < 4; i++) ts_dump[i*8 +: 8] = tstore[ts_index][i];
  end

  // Tag write monitor.
  initial begin
    logic [13:0] e;
    forever begin
      @(negedge clk);
      if (ts_w) begin
        chk("ts_w_expected", {31'd0, exp_ts.size() != 0}, 1);
        if (exp_ts.size() != 0) begin
          e = exp_ts.pop_front();
          chk("ts_index", ts_index, e[13:12]);
          chk("ts_way", ts_way, e[11:8]);
          chk("ts_tag", ts_tag, e[7:0]);
        end
        for (int i = 0; i < 4; i++) if (ts_way[i]) tstore[ts_index][i] = ts_tag;
      end
    end
  end

  // Response monitor.
  initial begin
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (resp_v) begin
        chk("resp_expected", {31'd0, exp_resp.size() != 0}, 1);
        if (exp_resp.size() != 0) begin
          e = exp_resp.pop_front();
          chk("resp_hit", resp_hit, e[4]);
          chk("resp_way", resp_way, e[3:0]);
        end
        resp_cyc = cyc;
        resp_cnt++;
      end
    end
  end

  // Memory model: checks each new transaction, acks after ack_dly cycles.
  initial begin
    int cnt;
    bit busy;
    logic [10:0] e;
    mem_ack = 1'b0;
    cnt = 0;
    busy = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!clr || !mem_req) begin
        busy = 0;
      end else begin
        if (!busy) begin
          busy = 1;
          cnt  = 0;
          chk("mem_expected", {31'd0, exp_mem.size() != 0}, 1);
          if (exp_mem.size() != 0) begin
            e = exp_mem.pop_front();
            chk("mem_we", mem_we, e[10]);
            chk("mem_addr", mem_addr, e[9:0]);
          end
        end
        cnt++;
        if (cnt >= ack_dly) begin
          mem_ack = 1'b1;
          busy = 0;
        end
      end
    end
  end

  // One request; way is the hit way or the expected victim.
  task automatic do_req(input logic [9:0] addr, input logic rw, input logic hit,
                        input logic [3:0] way, input logic ev, input logic [9:0] ev_addr);
    int lat, n0, t, acc;
    exp_resp.push_back({hit, way});
    if (!hit) begin
      if (ev) exp_mem.push_back({1'b1, ev_addr});
      exp_mem.push_back({1'b0, addr});
      exp_ts.push_back({addr[1:0], way, addr[9:2]});
    end
    lat = hit ? 2 : 3 + ack_dly + (ev ? ack_dly : 0);
    n0 = resp_cnt;
    @(negedge clk);
    chk("req_ready", req_ready, 1);
    req_v = 1'b1; req_addr = addr; req_rw = rw;
    acc = cyc;
    @(negedge clk);
    req_v = 1'b0;
    t = 0;
    while (resp_cnt == n0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (resp_cnt == n0) chk("resp_timeout", resp_cnt, n0 + 1);
    else                chk("latency", resp_cyc - acc, lat);
    chk("mem_left", exp_mem.size(), 0);
    chk("ts_left", exp_ts.size(), 0);
  endtask

  initial begin
    #300000;
    bad++;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int t;
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 4; w++) tstore[s][w] = 8'h00;
    hit_ovr_en = 1'b0; hit_ovr = '0;
    req_v = 1'b0; req_rw = 1'b0; req_addr = '0;
    clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_v", resp_v, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_way", resp_way, 0);
    chk("rst_ts_w", ts_w, 0);
    chk("rst_ts_way", ts_way, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ts_index", ts_index, 0);
    chk("rst_ts_tag", ts_tag, 0);
    clr = 1'b1;

    // Cold miss then hit on 0x2A1 (tag A8, idx 1).
    do_req(10'h2A1, 1'b0, 1'b0, 4'b0001, 1'b0, 10'h0);
    do_req(10'h2A1, 1'b0, 1'b1, 4'b0001, 1'b0, 10'h0);

    // Fill the rest of idx 1; rr wraps to 0 so the fifth tag lands in way 0.
    do_req(10'h2C5, 1'b0, 1'b0, 4'b0010, 1'b0, 10'h0);
    do_req(10'h2C9, 1'b0, 1'b0, 4'b0100, 1'b0, 10'h0);
    do_req(10'h2CD, 1'b0, 1'b0, 4'b1000, 1'b0, 10'h0);
    do_req(10'h301, 1'b0, 1'b0, 4'b0001, 1'b0, 10'h0);

    // idx 3: tag 0x11 ends in way 2, two more fills bring rr to 2.
    do_req(10'h083, 1'b0, 1'b0, 4'b0001, 1'b0, 10'h0);
    do_req(10'h087, 1'b0, 1'b0, 4'b0010, 1'b0, 10'h0);
    do_req(10'h047, 1'b0, 1'b0, 4'b0100, 1'b0, 10'h0);
    do_req(10'h08F, 1'b0, 1'b0, 4'b1000, 1'b0, 10'h0);
    do_req(10'h093, 1'b0, 1'b0, 4'b0001, 1'b0, 10'h0);
    do_req(10'h097, 1'b0, 1'b0, 4'b0010, 1'b0, 10'h0);
    // Write hit dirties way 2, then a write miss evicts it.
    do_req(10'h047, 1'b1, 1'b1, 4'b0100, 1'b0, 10'h0);
    do_req(10'h0C3, 1'b1, 1'b0, 4'b0100, 1'b1, 10'h047);
    // Walk rr back to 2 with clean read fills; the new line stayed dirty.
    do_req(10'h0C7, 1'b0, 1'b0, 4'b1000, 1'b0, 10'h0);
    do_req(10'h0CB, 1'b0, 1'b0, 4'b0001, 1'b0, 10'h0);
    do_req(10'h0CF, 1'b0, 1'b0, 4'b0010, 1'b0, 10'h0);
    do_req(10'h0D3, 1'b0, 1'b0, 4'b0100, 1'b1, 10'h0C3);

    // Raw compare hit on an invalid way is a miss; single-cycle fill.
    ack_dly = 1;
    hit_ovr_en = 1'b1; hit_ovr = 4'b0100;
    do_req(10'h0F2, 1'b0, 1'b0, 4'b0001, 1'b0, 10'h0);
    hit_ovr_en = 1'b0;
    ack_dly = 2;

    // Reset in the middle of a fill.
    ack_dly = 1000;
    exp_mem.push_back({1'b0, 10'h154});
    @(negedge clk);
    req_v = 1'b1; req_addr = 10'h154; req_rw = 1'b0;
    @(negedge clk);
    req_v = 1'b0;
    t = 0;
    while (!mem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("fill_started", mem_req, 1);
    @(negedge clk);
    #2 clr = 1'b0;
    #1;
    chk("clr_mem_req", mem_req, 0);
    chk("clr_ts_w", ts_w, 0);
    chk("clr_req_ready", req_ready, 1);
    @(negedge clk);
    clr = 1'b1;
    ack_dly = 2;
    exp_mem.delete();
    // 0x2CD still sits in the tag store, but valid bits are gone.
    do_req(10'h2CD, 1'b0, 1'b0, 4'b0001, 1'b0, 10'h0);

    repeat (3) @(negedge clk);
    chk("resp_left", exp_resp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
